// File: rtl/vga_fb_pkg.sv
// Shared constants, state encoding and RAM request payload for the framebuffer arbiter.
package vga_fb_pkg;

  localparam int unsigned FB_W    = 160;
  localparam int unsigned FB_H    = 120;
  localparam int unsigned DW      = 12;
  localparam int unsigned AW      = 15;
  localparam int unsigned FB_SIZE = FB_W * FB_H;
  localparam int unsigned LB_AW   = 8;
  localparam int unsigned LINE_W  = 7;
  localparam int unsigned X_W     = 10;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN
  } state_t;

  typedef struct packed {
    logic          en;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ram_req_t;

endpackage

// File: rtl/vga_line_buffer.sv
// One framebuffer row of pixels: synchronous write port for fills, synchronous read port for video.
module vga_line_buffer
  import vga_fb_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_wr_en,
  input  logic [LB_AW-1:0] i_wr_addr,
  input  logic [DW-1:0]    i_wr_data,
  input  logic             i_rd_en,
  input  logic [LB_AW-1:0] i_rd_addr,
  output logic [DW-1:0]    o_rd_data
);

  logic [DW-1:0] mem [FB_W];

  // Storage is intentionally unreset; a reset mid-fill leaves the partial row in place.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) o_rd_data <= mem[i_rd_addr];
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Arbitrates the single-port framebuffer RAM between row fills and host writes,
// and serves 4x-upscaled pixels from the fetched row.
module vga_fb_arbiter
  import vga_fb_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_pix_stb,
  input  logic              i_video_on,
  input  logic [X_W-1:0]    i_pix_x,
  input  logic              i_fill_req,
  input  logic [LINE_W-1:0] i_fill_line,
  input  logic              i_host_valid,
  input  logic [AW-1:0]     i_host_addr,
  input  logic [DW-1:0]     i_host_wdata,
  output logic              o_host_ready,
  output logic              o_ram_en,
  output logic              o_ram_we,
  output logic [AW-1:0]     o_ram_addr,
  output logic [DW-1:0]     o_ram_wdata,
  input  logic [DW-1:0]     i_ram_rdata,
  output logic              o_busy,
  output logic              o_fill_err,
  output logic              o_host_err,
  output logic [DW-1:0]     o_rgb
);

  state_t           state_q, state_d;
  logic [AW-1:0]    base_q, base_d;
  logic [LB_AW-1:0] k_q, k_d;
  logic             drain_q, drain_d;
  ram_req_t         ram_q, ram_d;
  logic             rd1_q, rd1_d, rd2_q;
  logic [LB_AW-1:0] idx1_q, idx1_d, idx2_q;
  logic             busy_q, busy_d;
  logic             fill_err_q, fill_err_d;
  logic             host_err_q, host_err_d;
  logic             stb_q, von_q;
  logic [DW-1:0]    rgb_q, rgb_d;
  logic [DW-1:0]    lb_rd_data;
  logic             fill_ok_c;
  logic             host_acc_c;
  logic             unused_pix_lsb;

  assign unused_pix_lsb = ^i_pix_x[1:0];

  // Fill wins the cycle combinationally, so a host request alongside it is not accepted.
  assign o_host_ready = (state_q == IDLE) && !i_fill_req;
  assign fill_ok_c    = i_fill_req && (state_q == IDLE) && (i_fill_line < LINE_W'(FB_H));
  assign host_acc_c   = i_host_valid && o_host_ready;

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    k_d        = k_q;
    drain_d    = drain_q;
    ram_d      = ram_q;
    ram_d.en   = 1'b0;
    ram_d.we   = 1'b0;
    rd1_d      = 1'b0;
    idx1_d     = idx1_q;
    fill_err_d = i_fill_req && !fill_ok_c;
    host_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (fill_ok_c) begin
          state_d = FILL;
          base_d  = AW'(i_fill_line * FB_W);
          k_d     = '0;
        end else if (host_acc_c) begin
          if (i_host_addr < AW'(FB_SIZE)) begin
            ram_d.en   = 1'b1;
            ram_d.we   = 1'b1;
            ram_d.addr = i_host_addr;
            ram_d.data = i_host_wdata;
          end else begin
            host_err_d = 1'b1;
          end
        end
      end
      FILL: begin
        ram_d.en   = 1'b1;
        ram_d.addr = base_q + AW'(k_q);
        rd1_d      = 1'b1;
        idx1_d     = k_q;
        if (k_q == LB_AW'(FB_W - 1)) begin
          state_d = DRAIN;
          drain_d = 1'b0;
        end else begin
          k_d = k_q + LB_AW'(1);
        end
      end
      DRAIN: begin
        if (drain_q) begin
          state_d = IDLE;
          drain_d = 1'b0;
        end else begin
          drain_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    rgb_d  = rgb_q;
    if (stb_q) rgb_d = von_q ? lb_rd_data : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      k_q        <= '0;
      drain_q    <= 1'b0;
      ram_q      <= '0;
      rd1_q      <= 1'b0;
      rd2_q      <= 1'b0;
      idx1_q     <= '0;
      idx2_q     <= '0;
      busy_q     <= 1'b0;
      fill_err_q <= 1'b0;
      host_err_q <= 1'b0;
      stb_q      <= 1'b0;
      von_q      <= 1'b0;
      rgb_q      <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      k_q        <= k_d;
      drain_q    <= drain_d;
      ram_q      <= ram_d;
      rd1_q      <= rd1_d;
      rd2_q      <= rd1_q;
      idx1_q     <= idx1_d;
      idx2_q     <= idx1_q;
      busy_q     <= busy_d;
      fill_err_q <= fill_err_d;
      host_err_q <= host_err_d;
      stb_q      <= i_pix_stb;
      von_q      <= i_video_on;
      rgb_q      <= rgb_d;
    end
  end

  assign o_ram_en    = ram_q.en;
  assign o_ram_we    = ram_q.we;
  assign o_ram_addr  = ram_q.addr;
  assign o_ram_wdata = ram_q.data;
  assign o_busy      = busy_q;
  assign o_fill_err  = fill_err_q;
  assign o_host_err  = host_err_q;
  assign o_rgb       = rgb_q;

  // Read data lands two cycles after the fill decision for index k.
  vga_line_buffer u_line_buffer (
    .i_clk     (i_clk),
    .i_wr_en   (rd2_q),
    .i_wr_addr (idx2_q),
    .i_wr_data (i_ram_rdata),
    .i_rd_en   (i_pix_stb),
    .i_rd_addr (i_pix_x[X_W-1:2]),
    .o_rd_data (lb_rd_data)
  );

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: scenario tasks plus randomized fills against a row model.
module tb_vga_fb_arbiter;
  import vga_fb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pix_stb, video_on, fill_req, host_valid;
  logic [9:0]  pix_x;
  logic [6:0]  fill_line;
  logic [14:0] host_addr;
  logic [11:0] host_wdata;
  logic        host_ready, ram_en, ram_we, busy, fill_err, host_err;
  logic [14:0] ram_addr;
  logic [11:0] ram_wdata, rgb;
  logic [11:0] ram_rdata = 12'h000;

  int checks = 0;
  int failures = 0;
  logic [11:0] ram_mem [int];
  logic [11:0] ref_mem [int];
  logic [11:0] lb_model [160];
  logic [11:0] exp_rgb = 12'h000;

  always #5 clk = ~clk;

  vga_fb_arbiter dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_stb(pix_stb), .i_video_on(video_on),
    .i_pix_x(pix_x), .i_fill_req(fill_req), .i_fill_line(fill_line),
    .i_host_valid(host_valid), .i_host_addr(host_addr), .i_host_wdata(host_wdata),
    .o_host_ready(host_ready), .o_ram_en(ram_en), .o_ram_we(ram_we),
    .o_ram_addr(ram_addr), .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata),
    .o_busy(busy), .o_fill_err(fill_err), .o_host_err(host_err), .o_rgb(rgb)
  );

  function automatic logic [11:0] ram_val(input int a);
    if (ram_mem.exists(a)) return ram_mem[a];
    return 12'(a);
  endfunction

  function automatic logic [11:0] ref_val(input int a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return 12'(a);
  endfunction

  // External RAM: power-on content mem[a] = a[11:0], one-cycle read latency.
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) ram_mem[int'(ram_addr)] = ram_wdata;
      else ram_rdata <= ram_val(int'(ram_addr));
    end
  end

  task automatic run_fill(input logic [6:0] line, input int inj_cyc, input logic [6:0] inj_line,
                          output int nbusy, output int nreads, output int nbad, output int nferr);
    int base;
    base = int'(line) * 160;
    nbusy = 0; nreads = 0; nbad = 0; nferr = 0;
    @(negedge clk);
    fill_req = 1'b1; fill_line = line;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      fill_req = 1'b0;
      if (fill_err) nferr++;
      if (!busy) break;
      nbusy++;
      if (ram_en && !ram_we) begin
        if (int'(ram_addr) != base + nreads) nbad++;
        nreads++;
      end
      if (c == inj_cyc) begin fill_req = 1'b1; fill_line = inj_line; end
    end
    for (int i = 0; i < 160; i++) lb_model[i] = ref_val(base + i);
  endtask

  task automatic read_pix(input logic [9:0] x, input logic von, output logic [11:0] held,
                          output logic [11:0] got);
    @(negedge clk);
    pix_stb = 1'b1; pix_x = x; video_on = von;
    @(negedge clk);
    pix_stb = 1'b0;
    held = rgb;
    @(negedge clk);
    got = rgb;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, ram_en, ram_we, fill_err, host_err} !== 5'b0 || ram_addr !== 15'd0 ||
        ram_wdata !== 12'd0 || rgb !== 12'd0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%0b en=%0b we=%0b ferr=%0b herr=%0b addr=%0d wd=%h rgb=%h want all 0",
               busy, ram_en, ram_we, fill_err, host_err, ram_addr, ram_wdata, rgb);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (host_ready !== 1'b1 || busy !== 1'b0 || rgb !== 12'd0) begin
      failures++;
      $display("FAIL reset_release got ready=%0b busy=%0b rgb=%h want 1 0 000", host_ready, busy, rgb);
    end
  endtask

  task automatic test_host_write();
    @(negedge clk);
    host_valid = 1'b1; host_addr = 15'd5; host_wdata = 12'hABC;
    ref_mem[5] = 12'hABC;
    #1;
    checks++;
    if (host_ready !== 1'b1) begin failures++; $display("FAIL host_ready got=%0b want=1", host_ready); end
    @(negedge clk);
    host_valid = 1'b0;
    checks++;
    if ({ram_en, ram_we} !== 2'b11 || ram_addr !== 15'd5 || ram_wdata !== 12'hABC || host_err !== 1'b0) begin
      failures++;
      $display("FAIL host_write got en=%0b we=%0b addr=%0d wd=%h herr=%0b want 1 1 5 abc 0",
               ram_en, ram_we, ram_addr, ram_wdata, host_err);
    end
    @(negedge clk);
    checks++;
    if (ram_en !== 1'b0 || ram_we !== 1'b0 || ram_addr !== 15'd5) begin
      failures++;
      $display("FAIL host_idle_hold got en=%0b we=%0b addr=%0d want 0 0 5", ram_en, ram_we, ram_addr);
    end
    host_valid = 1'b1; host_addr = 15'd19200; host_wdata = 12'h555;
    #1;
    checks++;
    if (host_ready !== 1'b1) begin failures++; $display("FAIL host_oob_ready got=%0b want=1", host_ready); end
    @(negedge clk);
    host_valid = 1'b0;
    checks++;
    if (host_err !== 1'b1 || ram_en !== 1'b0) begin
      failures++;
      $display("FAIL host_oob got herr=%0b en=%0b want 1 0", host_err, ram_en);
    end
    @(negedge clk);
    checks++;
    if (host_err !== 1'b0 || ram_en !== 1'b0) begin
      failures++;
      $display("FAIL host_oob_pulse got herr=%0b en=%0b want 0 0", host_err, ram_en);
    end
  endtask

  task automatic test_fill();
    int nb, nr, nbad, nf;
    logic [11:0] held, got;
    run_fill(7'd2, 0, 7'd0, nb, nr, nbad, nf);
    checks++;
    if (nb != 162 || nr != 160 || nbad != 0 || nf != 0) begin
      failures++;
      $display("FAIL fill_line2 got busy=%0d reads=%0d bad=%0d ferr=%0d want 162 160 0 0", nb, nr, nbad, nf);
    end
    read_pix(10'd8, 1'b1, held, got);
    checks++;
    if (held !== exp_rgb || got !== 12'h142) begin
      failures++;
      $display("FAIL pix_x8 got held=%h rgb=%h want %h 142", held, got, exp_rgb);
    end
    exp_rgb = 12'h142;
    read_pix(10'd8, 1'b0, held, got);
    checks++;
    if (held !== exp_rgb || got !== 12'h000) begin
      failures++;
      $display("FAIL pix_blank got held=%h rgb=%h want %h 000", held, got, exp_rgb);
    end
    exp_rgb = 12'h000;
  endtask

  task automatic test_contention();
    int nb, nw, nrdy;
    nb = 0; nw = 0; nrdy = 0;
    @(negedge clk);
    fill_req = 1'b1; fill_line = 7'd4;
    host_valid = 1'b1; host_addr = 15'd7; host_wdata = 12'h123;
    ref_mem[7] = 12'h123;
    #1;
    checks++;
    if (host_ready !== 1'b0) begin failures++; $display("FAIL contend_ready got=%0b want=0", host_ready); end
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      fill_req = 1'b0;
      if (!busy) break;
      nb++;
      if (ram_en && ram_we) nw++;
      if (host_ready) nrdy++;
    end
    checks++;
    if (nb != 162 || nw != 0 || nrdy != 0) begin
      failures++;
      $display("FAIL contend_fill got busy=%0d writes=%0d ready_hi=%0d want 162 0 0", nb, nw, nrdy);
    end
    for (int i = 0; i < 160; i++) lb_model[i] = ref_val(640 + i);
    #1;
    checks++;
    if (host_ready !== 1'b1) begin failures++; $display("FAIL contend_ready_after got=%0b want=1", host_ready); end
    @(negedge clk);
    host_valid = 1'b0;
    checks++;
    if ({ram_en, ram_we} !== 2'b11 || ram_addr !== 15'd7 || ram_wdata !== 12'h123) begin
      failures++;
      $display("FAIL contend_write got en=%0b we=%0b addr=%0d wd=%h want 1 1 7 123",
               ram_en, ram_we, ram_addr, ram_wdata);
    end
  endtask

  task automatic test_errors();
    int nb, nr, nbad, nf;
    run_fill(7'd2, 50, 7'd5, nb, nr, nbad, nf);
    checks++;
    if (nb != 162 || nr != 160 || nbad != 0 || nf != 1) begin
      failures++;
      $display("FAIL fill_busy_reject got busy=%0d reads=%0d bad=%0d ferr=%0d want 162 160 0 1", nb, nr, nbad, nf);
    end
    @(negedge clk);
    fill_req = 1'b1; fill_line = 7'd120;
    @(negedge clk);
    fill_req = 1'b0;
    checks++;
    if (fill_err !== 1'b1 || busy !== 1'b0 || ram_en !== 1'b0) begin
      failures++;
      $display("FAIL fill_line120 got ferr=%0b busy=%0b en=%0b want 1 0 0", fill_err, busy, ram_en);
    end
    @(negedge clk);
    checks++;
    if (fill_err !== 1'b0 || busy !== 1'b0 || ram_en !== 1'b0) begin
      failures++;
      $display("FAIL fill_line120_pulse got ferr=%0b busy=%0b en=%0b want 0 0 0", fill_err, busy, ram_en);
    end
  endtask

  task automatic test_reset_mid_fill();
    int nb, nr, nbad, nf;
    logic [11:0] held, got;
    read_pix(10'd8, 1'b1, held, got);
    exp_rgb = got;
    @(negedge clk);
    fill_req = 1'b1; fill_line = 7'd2;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      fill_req = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, ram_en, ram_we, fill_err, host_err} !== 5'b0 || ram_addr !== 15'd0 || rgb !== 12'd0) begin
      failures++;
      $display("FAIL reset_mid_fill got busy=%0b en=%0b we=%0b addr=%0d rgb=%h (held %h) want all 0",
               busy, ram_en, ram_we, ram_addr, rgb, exp_rgb);
    end
    exp_rgb = 12'h000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (host_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_release got ready=%0b busy=%0b want 1 0", host_ready, busy);
    end
    run_fill(7'd3, 0, 7'd0, nb, nr, nbad, nf);
    checks++;
    if (nb != 162 || nr != 160 || nbad != 0 || nf != 0) begin
      failures++;
      $display("FAIL fill_line3 got busy=%0d reads=%0d bad=%0d ferr=%0d want 162 160 0 0", nb, nr, nbad, nf);
    end
    read_pix(10'd43, 1'b1, held, got);
    checks++;
    if (held !== exp_rgb || got !== lb_model[10]) begin
      failures++;
      $display("FAIL pix_line3 got held=%h rgb=%h want %h %h", held, got, exp_rgb, lb_model[10]);
    end
    exp_rgb = lb_model[10];
  endtask

  task automatic test_random();
    int nb, nr, nbad, nf, line, a, nw;
    logic [11:0] d, held, got, want;
    logic [9:0] x;
    logic von;
    for (int it = 0; it < 6; it++) begin
      line = int'($urandom_range(0, 119));
      nw = int'($urandom_range(1, 3));
      for (int w = 0; w < nw; w++) begin
        a = line * 160 + int'($urandom_range(0, 159));
        d = 12'($urandom);
        @(negedge clk);
        host_valid = 1'b1; host_addr = 15'(a); host_wdata = d;
        ref_mem[a] = d;
        @(negedge clk);
        host_valid = 1'b0;
        checks++;
        if ({ram_en, ram_we} !== 2'b11 || int'(ram_addr) != a || ram_wdata !== d) begin
          failures++;
          $display("FAIL rand_write got en=%0b we=%0b addr=%0d wd=%h want 1 1 %0d %h",
                   ram_en, ram_we, ram_addr, ram_wdata, a, d);
        end
      end
      @(negedge clk);
      host_valid = 1'b1; host_addr = 15'($urandom_range(19200, 32767)); host_wdata = 12'($urandom);
      @(negedge clk);
      host_valid = 1'b0;
      checks++;
      if (host_err !== 1'b1 || ram_en !== 1'b0) begin
        failures++;
        $display("FAIL rand_oob got herr=%0b en=%0b want 1 0", host_err, ram_en);
      end
      run_fill(7'(line), 0, 7'd0, nb, nr, nbad, nf);
      checks++;
      if (nb != 162 || nr != 160 || nbad != 0 || nf != 0) begin
        failures++;
        $display("FAIL rand_fill line=%0d got busy=%0d reads=%0d bad=%0d ferr=%0d want 162 160 0 0",
                 line, nb, nr, nbad, nf);
      end
      for (int p = 0; p < 6; p++) begin
        x = 10'($urandom_range(0, 639));
        von = ($urandom_range(0, 3) != 0);
        want = von ? lb_model[int'(x) / 4] : 12'h000;
        read_pix(x, von, held, got);
        checks++;
        if (held !== exp_rgb || got !== want) begin
          failures++;
          $display("FAIL rand_pix line=%0d x=%0d von=%0b got held=%h rgb=%h want %h %h",
                   line, x, von, held, got, exp_rgb, want);
        end
        exp_rgb = want;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; pix_stb = 1'b0; video_on = 1'b0; pix_x = '0;
    fill_req = 1'b0; fill_line = '0; host_valid = 1'b0; host_addr = '0; host_wdata = '0;
    test_reset();
    test_host_write();
    test_fill();
    test_contention();
    test_errors();
    test_reset_mid_fill();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
